vga_timing: RTL and testbench

Display timing generator for the 640x480 @ 60 Hz VGA output. It runs on the 25.2 MHz pixel clock and drives horizontal and vertical counters. From those counters it produces sync, data-enable and screen coordinates, plus a fetch-side coordinate stream that leads the displayed pixel by a fixed number of cycles. The lead lets the framebuffer read path line up its pixel data with `de`. It sits between the clock/reset block and the framebuffer scan-out / video output stage.

---
 rtl/gfx_pkg.sv | 48 ++++
 rtl/vga_sync_delay.sv | 39 +++
 rtl/vga_timing.sv | 130 +++++++++++++
 tb/tb_vga_timing.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gfx_pkg : VGA 640x480@60 timing defaults, coordinate and sync-entry types
// Rev 1.0
// ---------------------------------------------------------------------------
package gfx_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   valid;
    logic   hsync_n;
    logic   vsync_n;
    logic   line_start;
    logic   frame_start;
  } sync_entry_t;

  // Idle entry: nothing displayed, syncs released, no pulses, position kept.
  function automatic sync_entry_t idle_entry(input coord_t x, input coord_t y);
    sync_entry_t e;
    e.x           = x;
    e.y           = y;
    e.valid       = 1'b0;
    e.hsync_n     = 1'b1;
    e.vsync_n     = 1'b1;
    e.line_start  = 1'b0;
    e.frame_start = 1'b0;
    return e;
  endfunction

  function automatic logic in_window(input coord_t v, input int lo, input int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_sync_delay : DEPTH-stage shift register of sync entries, async clear to idle
// Rev 1.0
// ---------------------------------------------------------------------------
module vga_sync_delay
  import gfx_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_pix,
  input  logic        rst_n,
  input  sync_entry_t entry_in,
  output sync_entry_t entry_out
);

  sync_entry_t stage_q [DEPTH];
  sync_entry_t stage_d [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_d[i] = entry_in;
    end else begin : g_tail
      assign stage_d[i] = stage_q[i-1];
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
        stage_q[i] <= idle_entry('0, '0);
      end else begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign entry_out = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_timing : 640x480@60 counters with a lead-side fetch stream and aligned
//              display outputs. Optional frame counter: VGA_FRAME_COUNT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module vga_timing
  import gfx_pkg::*;
#(
  parameter int LOOKAHEAD = 2,
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic        clk_pix,
  input  logic        rst_n,
  input  logic        en,
  output logic [9:0]  fetch_x,
  output logic [9:0]  fetch_y,
  output logic        fetch_valid,
  output logic [9:0]  sx,
  output logic [9:0]  sy,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int     H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int     V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);

  coord_t      hc_q, hc_d;
  coord_t      vc_q, vc_d;
  logic        h_wrap;
  logic        lead_active;
  sync_entry_t lead_entry;
  sync_entry_t disp_entry;

  // Counters hold (not reset) while en is low.
  always_comb begin
    hc_d   = hc_q;
    vc_d   = vc_q;
    h_wrap = (hc_q == H_LAST);
    if (en) begin
      hc_d = h_wrap ? '0 : hc_q + 10'd1;
      if (h_wrap) begin
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // Lead-side entry; a disabled cycle injects an idle entry at the held position.
  always_comb begin
    lead_active = (int'(hc_q) < H_ACTIVE) && (int'(vc_q) < V_ACTIVE);
    lead_entry  = idle_entry(hc_q, vc_q);
    if (en) begin
      lead_entry.valid       = lead_active;
      lead_entry.hsync_n     = ~in_window(hc_q, H_ACTIVE + H_FP, H_SYNC);
      lead_entry.vsync_n     = ~in_window(vc_q, V_ACTIVE + V_FP, V_SYNC);
      lead_entry.line_start  = (hc_q == '0);
      lead_entry.frame_start = (hc_q == '0) && (vc_q == '0);
    end
  end

  assign fetch_x     = hc_q;
  assign fetch_y     = vc_q;
  assign fetch_valid = lead_active;

  vga_sync_delay #(
    .DEPTH     (LOOKAHEAD)
  ) u_delay (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .entry_in  (lead_entry),
    .entry_out (disp_entry)
  );

  assign sx          = disp_entry.x;
  assign sy          = disp_entry.y;
  assign de          = disp_entry.valid;
  assign hsync       = disp_entry.hsync_n;
  assign vsync       = disp_entry.vsync_n;
  assign line_start  = disp_entry.line_start;
  assign frame_start = disp_entry.frame_start;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (disp_entry.frame_start) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_timing : randomized-enable scoreboard bench for vga_timing (reduced raster)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_vga_timing;

  localparam int LA = 2;
  localparam int HA = 40, HF = 4, HS = 8, HB = 6;
  localparam int VA = 30, VF = 3, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  localparam logic [26:0] IDLE0 = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  logic       clk_pix = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en      = 1'b0;
  logic [9:0] fetch_x, fetch_y, sx, sy;
  logic       fetch_valid, de, hsync, vsync, line_start, frame_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count;
  int          fc_exp = 0;
`endif

  int checks = 0;
  int errors = 0;
  int hc_m   = 0;
  int vc_m   = 0;
  int cyc    = 0;
  int last_ls = -1;
  int last_fs = -1;
  bit mon_on  = 1'b0;
  bit per_on  = 1'b0;
  logic [26:0] exp_q[$];

  always #5 clk_pix = ~clk_pix;

  vga_timing #(
    .LOOKAHEAD   (LA),
    .H_ACTIVE    (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE    (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk_pix     (clk_pix),
    .rst_n       (rst_n),
    .en          (en),
    .fetch_x     (fetch_x),
    .fetch_y     (fetch_y),
    .fetch_valid (fetch_valid),
    .sx          (sx),
    .sy          (sy),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, "_disp"}, {sx, sy, de, hsync, vsync, line_start, frame_start}, IDLE0);
    check({name, "_fetch"}, {fetch_x, fetch_y, fetch_valid}, {10'd0, 10'd0, 1'b1});
`ifdef VGA_FRAME_COUNT_EN
    check({name, "_fcount"}, frame_count, 16'd0);
`endif
  endtask

  task automatic model_reset();
    hc_m = 0;
    vc_m = 0;
    exp_q.delete();
    for (int i = 0; i < LA - 1; i++) exp_q.push_back(IDLE0);
`ifdef VGA_FRAME_COUNT_EN
    fc_exp = 0;
`endif
  endtask

  // One pixel clock: drive en, check lead side, predict the display entry.
  task automatic step(input logic en_v);
    logic [26:0] e;
    @(negedge clk_pix);
    en = en_v;
    check("fetch", {fetch_x, fetch_y, fetch_valid},
          {10'(hc_m), 10'(vc_m), 1'(hc_m < HA && vc_m < VA)});
    if (en_v) begin
      e = {10'(hc_m), 10'(vc_m),
           1'(hc_m < HA && vc_m < VA),
           1'(!(hc_m >= HA + HF && hc_m < HA + HF + HS)),
           1'(!(vc_m >= VA + VF && vc_m < VA + VF + VS)),
           1'(hc_m == 0),
           1'(hc_m == 0 && vc_m == 0)};
      hc_m = hc_m + 1;
      if (hc_m == HT) begin
        hc_m = 0;
        vc_m = (vc_m + 1) % VT;
      end
    end else begin
      e = {10'(hc_m), 10'(vc_m), 5'b01100};
    end
    exp_q.push_back(e);
  endtask

  // Monitor: after every edge out of reset, pop the prediction and compare.
  initial begin
    logic [26:0] e;
    forever begin
      @(posedge clk_pix);
      #1;
      cyc++;
      if (!per_on) begin
        last_ls = -1;
        last_fs = -1;
      end
      if (rst_n && mon_on) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("display", {sx, sy, de, hsync, vsync, line_start, frame_start}, e);
`ifdef VGA_FRAME_COUNT_EN
          check("frame_count", frame_count, 16'(fc_exp));
          if (e[0]) fc_exp++;
`endif
        end
        if (per_on && line_start) begin
          if (last_ls >= 0) check("line_period", 64'(cyc - last_ls), 64'(HT));
          last_ls = cyc;
        end
        if (per_on && frame_start) begin
          if (last_fs >= 0) check("frame_period", 64'(cyc - last_fs), 64'(HT * VT));
          last_fs = cyc;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (5) @(negedge clk_pix);
    check_reset("reset");

    model_reset();
    @(posedge clk_pix);
    #3;
    rst_n  = 1'b1;
    mon_on = 1'b1;
    per_on = 1'b1;
    repeat (2 * HT * VT + 10) step(1'b1);

    // Enable drop mid-line: counters hold, display shows idle entries.
    per_on = 1'b0;
    while (hc_m != 30) step(1'b1);
    repeat (10) step(1'b0);
    repeat (3 * HT) step(1'b1);

    repeat (3 * HT * VT) step(1'($urandom_range(0, 7) != 0));

    // Asynchronous reset mid-frame, between clock edges.
    while (!(hc_m == 24 && vc_m == 20)) step(1'b1);
    step(1'b1);
    @(posedge clk_pix);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("reset_async");
    model_reset();
    repeat (3) @(posedge clk_pix);
    #1;
    check_reset("reset_hold");
    @(posedge clk_pix);
    #3;
    rst_n  = 1'b1;
    per_on = 1'b1;
    repeat (HT * VT + 10) step(1'b1);

    @(posedge clk_pix);
    #2;
    check("queue_depth", 64'(exp_q.size()), 64'(LA - 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
